// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared record type, FSM states and keep-count helper for the rx meter
package tc_pkg;

  localparam int REC_W    = 64;
  localparam int KEEP_MAX = 128;

  typedef struct packed {
    logic [31:0] gap;
    logic [15:0] len;
    logic [15:0] beats;
  } rec_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  // Callers zero-extend their tkeep to KEEP_MAX bits.
  function automatic logic [15:0] popcount(input logic [KEEP_MAX-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      n = n + {15'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tc_rec_fifo.sv
// rtl/tc_rec_fifo.sv - first-word-fall-through record queue
module tc_rec_fifo
  import tc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the slot in the same cycle, so a push into a full queue still lands.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/tc_rx_meter.sv
// rtl/tc_rx_meter.sv - register-slice pass-through that records gap/len/beats per packet
module tc_rx_meter
  import tc_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 1,
  parameter int REC_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [REC_W-1:0]         rec_tdata,
  output logic                     rec_tvalid,
  input  logic                     rec_tready,
  output logic [31:0]              drop_cnt
);

  localparam int KEEP_W = TDATA_WIDTH / 8;

  state_t              r_state;
  logic [31:0]         r_gap_cnt;
  logic [31:0]         r_sop_gap;
  logic [15:0]         r_len;
  logic [15:0]         r_beats;
  logic                r_first;

  logic                w_fire;
  logic                w_sop;
  logic                w_eop;
  logic [KEEP_MAX-1:0] w_keep_ext;
  logic [15:0]         w_keep_cnt;
  logic [15:0]         w_len_base;
  logic [15:0]         w_beats_base;
  logic [16:0]         w_len_sum;
  logic [15:0]         w_len_next;
  logic [15:0]         w_beats_next;
  logic [31:0]         w_gap;
  rec_t                w_rec;
  logic                w_rec_full;
  logic                w_rec_empty;
  logic                w_rec_pop;
  logic                w_drop;

  assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
  assign w_fire        = s_axis_tvalid & s_axis_tready;
  assign w_sop         = w_fire & (r_state == ST_IDLE);
  assign w_eop         = w_fire & s_axis_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (w_fire) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tkeep  <= s_axis_tkeep;
      m_axis_tuser  <= s_axis_tuser;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_comb begin
    w_keep_ext               = '0;
    w_keep_ext[KEEP_W-1:0]   = s_axis_tkeep;
  end

  assign w_keep_cnt   = popcount(w_keep_ext);
  // The SOP beat starts a fresh tally rather than adding to the last packet's leftovers.
  assign w_len_base   = w_sop ? 16'd0 : r_len;
  assign w_beats_base = w_sop ? 16'd0 : r_beats;
  assign w_len_sum    = {1'b0, w_len_base} + {1'b0, w_keep_cnt};
  assign w_len_next   = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];
  assign w_beats_next = (w_beats_base == 16'hFFFF) ? 16'hFFFF : w_beats_base + 16'd1;
  assign w_gap        = w_sop ? (r_first ? 32'd0 : r_gap_cnt) : r_sop_gap;
  assign w_rec        = {w_gap, w_len_next, w_beats_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_sop_gap <= '0;
      r_len     <= '0;
      r_beats   <= '0;
      r_first   <= 1'b1;
    end else begin
      if (w_eop) begin
        r_gap_cnt <= 32'd1;
      end else if ((r_state == ST_IDLE) && (r_gap_cnt != 32'hFFFF_FFFF)) begin
        r_gap_cnt <= r_gap_cnt + 32'd1;
      end

      if (w_eop) begin
        r_first <= 1'b0;
        r_len   <= '0;
        r_beats <= '0;
      end else if (w_fire) begin
        r_sop_gap <= w_gap;
        r_len     <= w_len_next;
        r_beats   <= w_beats_next;
      end

      case (r_state)
        ST_IDLE:   if (w_fire && !s_axis_tlast) r_state <= ST_IN_PKT;
        ST_IN_PKT: if (w_eop) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign rec_tvalid = ~w_rec_empty;
  assign w_rec_pop  = rec_tvalid & rec_tready;
  assign w_drop     = w_eop & w_rec_full & ~w_rec_pop;

  tc_rec_fifo #(
    .DEPTH (REC_DEPTH),
    .WIDTH (REC_W)
  ) u_rec_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_eop),
    .i_data  (w_rec),
    .i_pop   (w_rec_pop),
    .o_data  (rec_tdata),
    .o_empty (w_rec_empty),
    .o_full  (w_rec_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (w_drop && (drop_cnt != 32'hFFFF_FFFF)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_tc_rx_meter.sv
// tb/tb_tc_rx_meter.sv - randomized and directed checks of tc_rx_meter against a packet-level model
module tb_tc_rx_meter;

  localparam int DW    = 512;
  localparam int KW    = DW / 8;
  localparam int UW    = 1;
  localparam int DEPTH = 4;

  typedef logic [DW-1:0] wv_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [63:0]   rec_tdata;
  logic          rec_tvalid;
  logic          rec_tready;
  logic [31:0]   drop_cnt;

  tc_rx_meter #(
    .TDATA_WIDTH (DW),
    .TUSER_WIDTH (UW),
    .REC_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rec_tdata     (rec_tdata),
    .rec_tvalid    (rec_tvalid),
    .rec_tready    (rec_tready),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  // Model: egress queue, record queue, and per-packet tallies with EOP/SOP timestamps.
  beat_t       mq[$];
  logic [63:0] rq[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  longint      cyc      = 0;
  longint      last_eop = 0;
  bit          first     = 1'b1;
  bit          in_pkt    = 1'b0;
  bit          force_sat = 1'b0;
  longint      cur_gap, cur_len, cur_beats;
  logic [31:0] exp_drop = '0;

  task automatic check(input string tag, input wv_t got, input wv_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [KW-1:0] rand_keep();
    logic [KW-1:0] k;
    k = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) k = '1;
    return k;
  endfunction

  task automatic meter(input beat_t b);
    if (!in_pkt) begin
      if (first)          cur_gap = 0;
      else if (force_sat) cur_gap = 64'hFFFF_FFFF;
      else                cur_gap = (cyc - last_eop > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : cyc - last_eop;
      force_sat = 1'b0;
      cur_len   = 0;
      cur_beats = 0;
    end
    cur_len   = cur_len + $countones(b.keep);
    if (cur_len > 65535) cur_len = 65535;
    cur_beats = (cur_beats >= 65535) ? 65535 : cur_beats + 1;
    if (b.last) begin
      if (rq.size() < DEPTH) rq.push_back({cur_gap[31:0], cur_len[15:0], cur_beats[15:0]});
      else if (exp_drop != 32'hFFFF_FFFF) exp_drop++;
      first    = 1'b0;
      last_eop = cyc;
      in_pkt   = 1'b0;
    end else begin
      in_pkt = 1'b1;
    end
  endtask

  task automatic compare();
    check("m_tvalid", wv_t'(m_axis_tvalid), wv_t'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("m_tdata", m_axis_tdata, mq[0].data);
      check("m_tkeep", wv_t'(m_axis_tkeep), wv_t'(mq[0].keep));
      check("m_tuser", wv_t'(m_axis_tuser), wv_t'(mq[0].user));
      check("m_tlast", wv_t'(m_axis_tlast), wv_t'(mq[0].last));
    end
    check("rec_tvalid", wv_t'(rec_tvalid), wv_t'(rq.size() > 0));
    if (rq.size() > 0) check("rec_tdata", wv_t'(rec_tdata), wv_t'(rq[0]));
    check("drop_cnt", wv_t'(drop_cnt), wv_t'(exp_drop));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle(output bit fired);
    bit    out_fire, pop;
    beat_t b;
    #1;
    if (!rst) check("s_tready", wv_t'(s_axis_tready), wv_t'(m_axis_tready || mq.size() == 0));
    fired    = !rst && s_axis_tvalid && s_axis_tready;
    out_fire = (mq.size() > 0) && m_axis_tready;
    pop      = (rq.size() > 0) && rec_tready;
    b        = '{s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      rq.delete();
      exp_drop = '0;
      first    = 1'b1;
      in_pkt   = 1'b0;
    end else begin
      if (out_fire) void'(mq.pop_front());
      if (pop) void'(rq.pop_front());
      if (fired) begin
        mq.push_back(b);
        meter(b);
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    bit f;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) cycle(f);
  endtask

  task automatic send(input logic [KW-1:0] keep, input bit last);
    bit f;
    f = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tdata  = rand_data();
    s_axis_tuser  = UW'($urandom);
    for (int t = 0; t < 50 && !f; t++) cycle(f);
    check("accept", wv_t'(f), wv_t'(1'b1));
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    bit f;
    int n;
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    rec_tready    = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(f);
    check("rst_m_tdata", m_axis_tdata, '0);
    check("rst_m_tkeep", wv_t'(m_axis_tkeep), '0);
    rst = 1'b0;
    idle(2);

    // Back-to-back packets: 3x64B then a 4-byte single beat.
    send('1, 1'b0);
    send('1, 1'b0);
    send('1, 1'b1);
    check("pkt1_rec", wv_t'(rec_tdata), wv_t'({32'd0, 16'd192, 16'd3}));
    send(KW'(64'h0F), 1'b1);
    check("pkt2_rec", wv_t'(rec_tdata), wv_t'({32'd1, 16'd4, 16'd1}));

    // Egress stall mid-packet.
    send('1, 1'b0);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = rand_data();
    for (int i = 0; i < 5; i++) begin
      cycle(f);
      check("stall_ready", wv_t'(s_axis_tready), '0);
    end
    m_axis_tready = 1'b1;
    send('1, 1'b0);
    send('1, 1'b1);
    check("stall_len", wv_t'(rec_tdata[31:16]), wv_t'(16'd192));
    check("stall_beats", wv_t'(rec_tdata[15:0]), wv_t'(16'd3));

    // Ten idle cycles after EOP.
    idle(10);
    send(rand_keep(), 1'b1);
    check("gap11", wv_t'(rec_tdata[63:32]), wv_t'(32'd11));
    idle(1);

    // Record backpressure: six packets into a four-deep queue.
    rec_tready = 1'b0;
    for (int i = 0; i < 6; i++) send(rand_keep(), 1'b1);
    check("drop2", wv_t'(drop_cnt), wv_t'(32'd2));
    rec_tready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (rec_tvalid) n++;
      idle(1);
    end
    check("drain4", wv_t'(n), wv_t'(4));

    // Gap counter pinned at its ceiling.
    force dut.r_gap_cnt = 32'hFFFF_FFFF;
    idle(1);
    release dut.r_gap_cnt;
    idle(2);
    force_sat = 1'b1;
    send(rand_keep(), 1'b1);
    check("gap_sat", wv_t'(rec_tdata[63:32]), wv_t'(32'hFFFF_FFFF));
    idle(2);

    // Reset in the middle of a 4-beat packet.
    send('1, 1'b0);
    send('1, 1'b0);
    rst = 1'b1;
    idle(2);
    check("mrst_m_tvalid", wv_t'(m_axis_tvalid), '0);
    check("mrst_m_tdata", m_axis_tdata, '0);
    check("mrst_m_tkeep", wv_t'(m_axis_tkeep), '0);
    check("mrst_m_tuser", wv_t'(m_axis_tuser), '0);
    check("mrst_m_tlast", wv_t'(m_axis_tlast), '0);
    check("mrst_rec_tvalid", wv_t'(rec_tvalid), '0);
    check("mrst_drop", wv_t'(drop_cnt), '0);
    rst = 1'b0;
    idle(3);
    send('1, 1'b0);
    send(KW'(64'hFF), 1'b1);
    check("post_rst_gap", wv_t'(rec_tdata[63:32]), '0);
    check("post_rst_len", wv_t'(rec_tdata[31:16]), wv_t'(16'd72));

    // Randomized traffic with independent backpressure on both outputs.
    for (int i = 0; i < 3000; i++) begin
      m_axis_tready = ($urandom_range(0, 9) < 7);
      rec_tready    = ($urandom_range(0, 9) < 4);
      s_axis_tvalid = ($urandom_range(0, 9) < 7);
      s_axis_tkeep  = rand_keep();
      s_axis_tlast  = ($urandom_range(0, 3) == 0);
      s_axis_tdata  = rand_data();
      s_axis_tuser  = UW'($urandom);
      cycle(f);
    end
    m_axis_tready = 1'b1;
    rec_tready    = 1'b1;
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
